// File: rtl/ip_packet_rx.sv
// rtl/ip_packet_rx.sv - Ethernet/IPv4/UDP frame receiver that extracts a 10-bit message.
// Define IP_RX_CHECKSUM_CHECK_EN to reject frames with a bad IPv4 header checksum.
module ip_packet_rx #(
  parameter int DROP_COUNT_WIDTH = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [31:0]                 ACCELERATOR_IP_ADDRESS,
  input  logic [47:0]                 ACCELERATOR_MAC_ADDRESS,
  input  logic [15:0]                 ACCELERATOR_UDP_PORT,
  input  logic [7:0]                  MAC_DATA_IN,
  input  logic                        MAC_DATA_VALID,
  output logic                        MAC_DATA_READY,
  input  logic                        MAC_DATA_LAST,
  input  logic                        MAC_DATA_TUSER,
  output logic [47:0]                 SENDER_MAC_ADDRESS,
  output logic [31:0]                 SENDER_IP_ADDRESS,
  output logic [15:0]                 SENDER_UDP_PORT,
  output logic [9:0]                  SENDER_MESSAGE,
  output logic                        MESSAGE_VALID,
  input  logic                        MESSAGE_READY,
  output logic [DROP_COUNT_WIDTH-1:0] DROP_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DRAIN,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [5:0]                  r_idx;
  logic                        r_ready;
  logic                        r_msg_valid;
  logic                        r_dst_ucast;
  logic                        r_dst_bcast;
  logic [47:0]                 r_cap_mac;
  logic [31:0]                 r_cap_ip;
  logic [15:0]                 r_cap_port;
  logic [9:0]                  r_cap_msg;
  logic [47:0]                 r_sender_mac;
  logic [31:0]                 r_sender_ip;
  logic [15:0]                 r_sender_port;
  logic [9:0]                  r_sender_msg;
  logic [DROP_COUNT_WIDTH-1:0] r_drop_count;

  logic [5:0] w_idx;
  logic       w_xfer;
  logic       w_parse;
  logic [7:0] w_mac_byte;
  logic       w_dst_ucast;
  logic       w_dst_bcast;
  logic       w_dst_bad;
  logic       w_chk;
  logic [7:0] w_exp;
  logic       w_csum_bad;
  logic       w_mismatch;
  logic       w_drop;
  logic       w_commit;
  logic [9:0] w_commit_msg;

  assign w_xfer  = MAC_DATA_VALID & r_ready;
  assign w_parse = (r_state == S_IDLE) || (r_state == S_HEADER);
  // The byte accepted in IDLE is always byte 0, whatever r_idx holds.
  assign w_idx   = (r_state == S_IDLE) ? 6'd0 : r_idx;

  always_comb begin
    w_mac_byte = 8'h00;
    case (w_idx)
      6'd0:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[47:40];
      6'd1:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[39:32];
      6'd2:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[31:24];
      6'd3:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[23:16];
      6'd4:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[15:8];
      6'd5:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[7:0];
      default: w_mac_byte = 8'h00;
    endcase
  end

  // Unicast and broadcast candidates are tracked separately so a mixed address fails.
  assign w_dst_ucast = ((w_idx == 6'd0) | r_dst_ucast) & (MAC_DATA_IN == w_mac_byte);
  assign w_dst_bcast = ((w_idx == 6'd0) | r_dst_bcast) & (MAC_DATA_IN == 8'hFF);
  assign w_dst_bad   = (w_idx < 6'd6) & ~(w_dst_ucast | w_dst_bcast);

  always_comb begin
    w_chk = 1'b0;
    w_exp = 8'h00;
    case (w_idx)
      6'd12: begin w_chk = 1'b1; w_exp = 8'h08; end
      6'd13: begin w_chk = 1'b1; w_exp = 8'h00; end
      6'd14: begin w_chk = 1'b1; w_exp = 8'h45; end
      6'd23: begin w_chk = 1'b1; w_exp = 8'h11; end
      6'd30: begin w_chk = 1'b1; w_exp = ACCELERATOR_IP_ADDRESS[31:24]; end
      6'd31: begin w_chk = 1'b1; w_exp = ACCELERATOR_IP_ADDRESS[23:16]; end
      6'd32: begin w_chk = 1'b1; w_exp = ACCELERATOR_IP_ADDRESS[15:8]; end
      6'd33: begin w_chk = 1'b1; w_exp = ACCELERATOR_IP_ADDRESS[7:0]; end
      6'd36: begin w_chk = 1'b1; w_exp = ACCELERATOR_UDP_PORT[15:8]; end
      6'd37: begin w_chk = 1'b1; w_exp = ACCELERATOR_UDP_PORT[7:0]; end
      default: begin w_chk = 1'b0; w_exp = 8'h00; end
    endcase
  end

`ifdef IP_RX_CHECKSUM_CHECK_EN
  logic [15:0] r_csum;
  logic [7:0]  r_csum_hi;
  logic [16:0] w_csum_sum;
  logic [15:0] w_csum_next;

  assign w_csum_sum  = {1'b0, r_csum} + {1'b0, r_csum_hi, MAC_DATA_IN};
  assign w_csum_next = w_csum_sum[15:0] + {15'd0, w_csum_sum[16]};
  assign w_csum_bad  = (w_idx == 6'd33) & (w_csum_next != 16'hFFFF);

  // Even header bytes hold the high half of a word; the odd byte completes and adds it.
  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      r_csum    <= 16'h0000;
      r_csum_hi <= 8'h00;
    end else if (w_xfer && w_parse) begin
      if (w_idx == 6'd0) begin
        r_csum <= 16'h0000;
      end else if (w_idx >= 6'd14 && w_idx <= 6'd33) begin
        if (!w_idx[0]) r_csum_hi <= MAC_DATA_IN;
        else           r_csum    <= w_csum_next;
      end
    end
  end
`else
  assign w_csum_bad = 1'b0;
`endif

  assign w_mismatch = w_dst_bad | (w_chk & (MAC_DATA_IN != w_exp)) | w_csum_bad;

  always_ff @(posedge ACLK) begin
    if (!ARESET) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_drop   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE, S_HEADER: begin
        if (w_xfer) begin
          if (w_mismatch) begin
            if (MAC_DATA_LAST) begin
              w_drop = 1'b1;
              w_next = S_IDLE;
            end else begin
              w_next = S_DISCARD;
            end
          end else if (MAC_DATA_LAST && (w_idx < 6'd43)) begin
            w_drop = 1'b1;
            w_next = S_IDLE;
          end else if (w_idx == 6'd43) begin
            if (!MAC_DATA_LAST) begin
              w_next = S_DRAIN;
            end else if (MAC_DATA_TUSER) begin
              w_drop = 1'b1;
              w_next = S_IDLE;
            end else begin
              w_commit = 1'b1;
              w_next   = S_HOLD;
            end
          end else begin
            w_next = S_HEADER;
          end
        end
      end
      S_DRAIN: begin
        if (w_xfer && MAC_DATA_LAST) begin
          if (MAC_DATA_TUSER) begin
            w_drop = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_commit = 1'b1;
            w_next   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (MESSAGE_READY) w_next = S_IDLE;
      end
      S_DISCARD: begin
        if (w_xfer && MAC_DATA_LAST) begin
          w_drop = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they flip together.
  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      r_idx       <= 6'd0;
      r_ready     <= 1'b0;
      r_msg_valid <= 1'b0;
      r_dst_ucast <= 1'b0;
      r_dst_bcast <= 1'b0;
    end else begin
      r_ready     <= (w_next != S_HOLD);
      r_msg_valid <= (w_next == S_HOLD);
      if (w_xfer) begin
        r_idx <= (w_next == S_HEADER) ? (w_idx + 6'd1) : 6'd0;
        if (w_parse && (w_idx < 6'd6)) begin
          r_dst_ucast <= w_dst_ucast;
          r_dst_bcast <= w_dst_bcast;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      r_cap_mac  <= 48'h0;
      r_cap_ip   <= 32'h0;
      r_cap_port <= 16'h0;
      r_cap_msg  <= 10'h0;
    end else if (w_xfer && w_parse) begin
      if (w_idx >= 6'd6 && w_idx <= 6'd11) r_cap_mac <= {r_cap_mac[39:0], MAC_DATA_IN};
      if (w_idx >= 6'd26 && w_idx <= 6'd29) r_cap_ip <= {r_cap_ip[23:0], MAC_DATA_IN};
      if (w_idx == 6'd34 || w_idx == 6'd35) r_cap_port <= {r_cap_port[7:0], MAC_DATA_IN};
      if (w_idx == 6'd42) r_cap_msg[9:8] <= MAC_DATA_IN[1:0];
      if (w_idx == 6'd43) r_cap_msg[7:0] <= MAC_DATA_IN;
    end
  end

  // A frame ending on byte 43 commits with that byte taken straight from the input.
  assign w_commit_msg = (r_state == S_DRAIN) ? r_cap_msg : {r_cap_msg[9:8], MAC_DATA_IN};

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      r_sender_mac  <= 48'h0;
      r_sender_ip   <= 32'h0;
      r_sender_port <= 16'h0;
      r_sender_msg  <= 10'h0;
      r_drop_count  <= '0;
    end else begin
      if (w_commit) begin
        r_sender_mac  <= r_cap_mac;
        r_sender_ip   <= r_cap_ip;
        r_sender_port <= r_cap_port;
        r_sender_msg  <= w_commit_msg;
      end
      if (w_drop && (r_drop_count != {DROP_COUNT_WIDTH{1'b1}})) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  assign MAC_DATA_READY     = r_ready;
  assign MESSAGE_VALID      = r_msg_valid;
  assign SENDER_MAC_ADDRESS = r_sender_mac;
  assign SENDER_IP_ADDRESS  = r_sender_ip;
  assign SENDER_UDP_PORT    = r_sender_port;
  assign SENDER_MESSAGE     = r_sender_msg;
  assign DROP_COUNT         = r_drop_count;

endmodule

// File: tb/tb_ip_packet_rx.sv
// tb/tb_ip_packet_rx.sv - directed self-checking bench for ip_packet_rx.
// Uses a 2-bit drop counter so saturation is reachable in a short run.
module tb_ip_packet_rx;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic [31:0] ACCELERATOR_IP_ADDRESS = 32'h01020304;
  logic [47:0] ACCELERATOR_MAC_ADDRESS = 48'h54B00BEDABBA;
  logic [15:0] ACCELERATOR_UDP_PORT = 16'h66FF;
  logic [7:0]  MAC_DATA_IN = 8'h00;
  logic        MAC_DATA_VALID = 1'b0;
  logic        MAC_DATA_READY;
  logic        MAC_DATA_LAST = 1'b0;
  logic        MAC_DATA_TUSER = 1'b0;
  logic [47:0] SENDER_MAC_ADDRESS;
  logic [31:0] SENDER_IP_ADDRESS;
  logic [15:0] SENDER_UDP_PORT;
  logic [9:0]  SENDER_MESSAGE;
  logic        MESSAGE_VALID;
  logic        MESSAGE_READY = 1'b0;
  logic [1:0]  DROP_COUNT;

  int checks = 0;
  int errors = 0;
  logic [7:0] fr [0:59];

  ip_packet_rx #(.DROP_COUNT_WIDTH(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ACCELERATOR_IP_ADDRESS(ACCELERATOR_IP_ADDRESS),
    .ACCELERATOR_MAC_ADDRESS(ACCELERATOR_MAC_ADDRESS),
    .ACCELERATOR_UDP_PORT(ACCELERATOR_UDP_PORT),
    .MAC_DATA_IN(MAC_DATA_IN), .MAC_DATA_VALID(MAC_DATA_VALID),
    .MAC_DATA_READY(MAC_DATA_READY), .MAC_DATA_LAST(MAC_DATA_LAST),
    .MAC_DATA_TUSER(MAC_DATA_TUSER),
    .SENDER_MAC_ADDRESS(SENDER_MAC_ADDRESS), .SENDER_IP_ADDRESS(SENDER_IP_ADDRESS),
    .SENDER_UDP_PORT(SENDER_UDP_PORT), .SENDER_MESSAGE(SENDER_MESSAGE),
    .MESSAGE_VALID(MESSAGE_VALID), .MESSAGE_READY(MESSAGE_READY),
    .DROP_COUNT(DROP_COUNT)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [31:0] sip,
                       input logic [31:0] dip, input logic [9:0] msg);
    logic [31:0] sum;
    logic [47:0] smac;
    smac = 48'h32DABBADEBD5;
    for (int i = 0; i < 60; i++) fr[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fr[i]     = dst[47-8*i -: 8];
      fr[6 + i] = smac[47-8*i -: 8];
    end
    fr[12] = 8'h08; fr[13] = 8'h00; fr[14] = 8'h45; fr[17] = 8'h2E;
    fr[22] = 8'h40; fr[23] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      fr[26 + i] = sip[31-8*i -: 8];
      fr[30 + i] = dip[31-8*i -: 8];
    end
    fr[34] = 8'h99; fr[35] = 8'hDD; fr[36] = 8'h66; fr[37] = 8'hFF; fr[39] = 8'h0A;
    fr[42] = {6'd0, msg[9:8]}; fr[43] = msg[7:0];
    sum = 32'h0;
    for (int i = 14; i < 34; i += 2) sum = sum + {16'h0, fr[i], fr[i+1]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    fr[24] = ~sum[15:8];
    fr[25] = ~sum[7:0];
  endtask

  task automatic put(input logic [7:0] b, input logic last, input logic tuser);
    int n;
    n = 0;
    MAC_DATA_IN = b; MAC_DATA_LAST = last; MAC_DATA_TUSER = tuser; MAC_DATA_VALID = 1'b1;
    forever begin
      @(negedge ACLK);
      if (MAC_DATA_READY) break;
      n++;
      if (n > 200) begin
        check("ready_timeout", 48'd0, 48'd1);
        break;
      end
    end
    @(posedge ACLK); #1;
  endtask

  task automatic send(input int len, input logic tuser, input logic gaps, input int stop_at);
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) break;
      if (gaps && (i == 5 || i == 20 || i == 33)) begin
        MAC_DATA_VALID = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
      end
      put(fr[i], (i == len - 1), tuser && (i == len - 1));
    end
    MAC_DATA_VALID = 1'b0; MAC_DATA_LAST = 1'b0; MAC_DATA_TUSER = 1'b0;
  endtask

  task automatic handshake();
    MESSAGE_READY = 1'b1;
    @(posedge ACLK); #1;
    MESSAGE_READY = 1'b0;
    check("hs_mvalid", {47'd0, MESSAGE_VALID}, 48'd0);
    check("hs_ready", {47'd0, MAC_DATA_READY}, 48'd1);
  endtask

  initial begin
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_ready", {47'd0, MAC_DATA_READY}, 48'd0);
    check("rst_mvalid", {47'd0, MESSAGE_VALID}, 48'd0);
    check("rst_drop", {46'd0, DROP_COUNT}, 48'd0);
    check("rst_msg", {38'd0, SENDER_MESSAGE}, 48'd0);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("rel_ready", {47'd0, MAC_DATA_READY}, 48'd1);

    // Valid 60-byte frame.
    build(48'h54B00BEDABBA, 32'h0A0B0C0D, 32'h01020304, 10'h1FF);
    send(60, 1'b0, 1'b0, -1);
    check("v_mvalid", {47'd0, MESSAGE_VALID}, 48'd1);
    check("v_ready", {47'd0, MAC_DATA_READY}, 48'd0);
    check("v_msg", {38'd0, SENDER_MESSAGE}, 48'h1FF);
    check("v_ip", {16'd0, SENDER_IP_ADDRESS}, 48'h0A0B0C0D);
    check("v_port", {32'd0, SENDER_UDP_PORT}, 48'h99DD);
    check("v_mac", SENDER_MAC_ADDRESS, 48'h32DABBADEBD5);
    check("v_drop", {46'd0, DROP_COUNT}, 48'd0);
    handshake();

    // Wrong destination IP; different source IP shows SENDER_* are left alone.
    build(48'h54B00BEDABBA, 32'hC0A80001, 32'h01020305, 10'h2AA);
    send(60, 1'b0, 1'b0, -1);
    check("wd_mvalid", {47'd0, MESSAGE_VALID}, 48'd0);
    check("wd_drop", {46'd0, DROP_COUNT}, 48'd1);
    check("wd_ip", {16'd0, SENDER_IP_ADDRESS}, 48'h0A0B0C0D);
    check("wd_msg", {38'd0, SENDER_MESSAGE}, 48'h1FF);

    // Gapped frame held in HOLD while the next frame waits on byte 0.
    build(48'h54B00BEDABBA, 32'h0A0B0C0D, 32'h01020304, 10'h234);
    send(60, 1'b0, 1'b1, -1);
    check("bp_mvalid", {47'd0, MESSAGE_VALID}, 48'd1);
    build(48'h54B00BEDABBA, 32'h0A0B0C0D, 32'h01020304, 10'h1FF);
    MAC_DATA_IN = fr[0]; MAC_DATA_VALID = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge ACLK); #1;
      check("bp_hold_ready", {47'd0, MAC_DATA_READY}, 48'd0);
      check("bp_hold_msg", {38'd0, SENDER_MESSAGE}, 48'h234);
    end
    check("bp_hold_mvalid", {47'd0, MESSAGE_VALID}, 48'd1);
    handshake();
    send(60, 1'b0, 1'b0, -1);
    check("bp2_mvalid", {47'd0, MESSAGE_VALID}, 48'd1);
    check("bp2_msg", {38'd0, SENDER_MESSAGE}, 48'h1FF);
    handshake();

    // Broadcast destination, frame ending exactly on byte 43.
    build(48'hFFFFFFFFFFFF, 32'h0A0B0C0D, 32'h01020304, 10'h055);
    send(44, 1'b0, 1'b0, -1);
    check("bc44_mvalid", {47'd0, MESSAGE_VALID}, 48'd1);
    check("bc44_msg", {38'd0, SENDER_MESSAGE}, 48'h055);
    handshake();

    // Runt frame.
    build(48'h54B00BEDABBA, 32'h0A0B0C0D, 32'h01020304, 10'h1FF);
    send(30, 1'b0, 1'b0, -1);
    check("runt_mvalid", {47'd0, MESSAGE_VALID}, 48'd0);
    check("runt_drop", {46'd0, DROP_COUNT}, 48'd2);
    check("runt_ready", {47'd0, MAC_DATA_READY}, 48'd1);

    // TUSER on LAST of an otherwise good frame.
    build(48'h54B00BEDABBA, 32'h0A0B0C0D, 32'h01020304, 10'h0AB);
    send(60, 1'b1, 1'b0, -1);
    check("tuser_mvalid", {47'd0, MESSAGE_VALID}, 48'd0);
    check("tuser_drop", {46'd0, DROP_COUNT}, 48'd3);
    check("tuser_msg", {38'd0, SENDER_MESSAGE}, 48'h055);

    // Another runt saturates the 2-bit counter.
    build(48'h54B00BEDABBA, 32'h0A0B0C0D, 32'h01020304, 10'h1FF);
    send(20, 1'b0, 1'b0, -1);
    check("sat_drop", {46'd0, DROP_COUNT}, 48'd3);

    // Corrupted header checksum.
    build(48'h54B00BEDABBA, 32'h0A0B0C0D, 32'h01020304, 10'h1FF);
    fr[25] = fr[25] ^ 8'hFF;
    send(60, 1'b0, 1'b0, -1);
`ifdef IP_RX_CHECKSUM_CHECK_EN
    check("csum_mvalid", {47'd0, MESSAGE_VALID}, 48'd0);
    check("csum_msg", {38'd0, SENDER_MESSAGE}, 48'h055);
`else
    check("csum_mvalid", {47'd0, MESSAGE_VALID}, 48'd1);
    check("csum_msg", {38'd0, SENDER_MESSAGE}, 48'h1FF);
    handshake();
`endif

    // Reset at byte 20, then a fresh frame.
    build(48'h54B00BEDABBA, 32'h0A0B0C0D, 32'h01020304, 10'h1FF);
    send(60, 1'b0, 1'b0, 20);
    ARESET = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    check("mrst_drop", {46'd0, DROP_COUNT}, 48'd0);
    check("mrst_ready", {47'd0, MAC_DATA_READY}, 48'd0);
    check("mrst_ip", {16'd0, SENDER_IP_ADDRESS}, 48'd0);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("mrst_rel_ready", {47'd0, MAC_DATA_READY}, 48'd1);
    check("mrst_rel_mvalid", {47'd0, MESSAGE_VALID}, 48'd0);
    build(48'h54B00BEDABBA, 32'h0A0B0C0D, 32'h01020304, 10'h321);
    send(60, 1'b0, 1'b0, -1);
    check("fresh_mvalid", {47'd0, MESSAGE_VALID}, 48'd1);
    check("fresh_msg", {38'd0, SENDER_MESSAGE}, 48'h321);
    check("fresh_ip", {16'd0, SENDER_IP_ADDRESS}, 48'h0A0B0C0D);
    check("fresh_drop", {46'd0, DROP_COUNT}, 48'd0);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
